atm_ctrl_param: RTL and testbench
=================================

# atm_ctrl_param

Parametrised ATM session controller: accepts a card, checks a PIN digit-by-digit against the card's stored PIN, then executes one deposit or withdrawal against an internal balance. It is the DUT driven by the ATM tester. Relative to the fixed 4-digit controller it adds:
- configurable PIN length, attempt limit and amount width;
- a per-transaction withdrawal limit;
- saturating deposits;
- a digit-entry timeout.

## Interface
Parameters:
- PIN_DIGITS, 4, number of 4-bit BCD digits in PIN
- MONTO_W, 32, width of amounts and balance
- MAX_INTENTOS, 3, wrong-PIN attempts before lockout (>=2)
- SALDO_INICIAL, 300000, balance value after RESET
- LIMITE_RETIRO, 500000, maximum single withdrawal
- TIMEOUT_CYC, 64, idle cycles allowed between digits

Ports:
- CLK  in  1  rising-edge clock; only clock
- RESET  in  1  synchronous, active-high
- TARJETA_RECIBIDA  in  1  card present (level)
- PIN  in  4*PIN_DIGITS  stored PIN, MS digit entered first
- DIGITO  in  4  keypad digit
- DIGITO_STB  in  1  DIGITO valid this cycle
- TIPO_TRANS  in  1  0 deposit, 1 withdrawal; sampled with MONTO_STB
- MONTO  in  MONTO_W  amount
- MONTO_STB  in  1  MONTO/TIPO_TRANS valid this cycle
- BALANCE  out  MONTO_W  current balance
- BALANCE_ACTUALIZADO  out  1  1-cycle pulse, balance changed
- ENTREGAR_DINERO  out  1  1-cycle pulse, dispense MONTO
- FONDOS_INSUFICIENTES  out  1  1-cycle pulse
- LIMITE_EXCEDIDO  out  1  1-cycle pulse
- PIN_INCORRECTO  out  1  1-cycle pulse per failed attempt
- ADVERTENCIA  out  1  level, errors == MAX_INTENTOS-1
- BLOQUEO  out  1  level, sticky until RESET
- TIMEOUT  out  1  1-cycle pulse, digit entry abandoned

## Operation
- States: IDLE, PIN_ENTRY, TRANS, DONE, BLOCKED.
- IDLE → PIN_ENTRY when TARJETA_RECIBIDA=1. The digit index is cleared.
- MONTO_STB in any state except BLOCKED latches MONTO and TIPO_TRANS into the pending amount and sets the pending-valid flag. A later strobe overwrites the pending amount. The flag clears on DONE entry and on RESET.

PIN_ENTRY:
- Each DIGITO_STB compares DIGITO with digit[index] of PIN.
- Match, not last digit: index+1.
- Mismatch at any index:
  - PIN_INCORRECTO pulses and the error counter increments.
  - The index resets to 0; the remaining digits are not awaited.
- Error counter reaches MAX_INTENTOS: go to BLOCKED.
- Match on the last digit: error counter clears, go to TRANS.
- TIMEOUT_CYC consecutive cycles without DIGITO_STB: TIMEOUT pulses, index clears, go to IDLE. The error counter is unchanged.

TRANS waits for pending-valid, then in one cycle:
- Deposit: balance = min(balance+MONTO, 2^MONTO_W-1). BALANCE_ACTUALIZADO pulses. Saturation is silent.
- Withdrawal with MONTO > LIMITE_RETIRO: LIMITE_EXCEDIDO pulses; balance unchanged. The limit check takes priority over the funds check.
- Withdrawal with MONTO > balance: FONDOS_INSUFICIENTES pulses; balance unchanged.
- Otherwise: balance -= MONTO; BALANCE_ACTUALIZADO and ENTREGAR_DINERO pulse together.
- Then go to DONE.

DONE, BLOCKED and card removal:
- DONE: one transaction per card. Digits and amounts are ignored. Go to IDLE when TARJETA_RECIBIDA=0.
- BLOCKED: BLOQUEO=1. All inputs are ignored, including card removal. Only RESET exits.
- TARJETA_RECIBIDA=0 in PIN_ENTRY or TRANS aborts to IDLE with no pulses.
- The error counter persists across card sessions and clears only on a correct PIN or RESET.
- ADVERTENCIA follows the counter combinationally from registered state.

## Timing
- Reset values:
  - state IDLE, index 0, errors 0, timeout counter 0, pending-valid 0;
  - BALANCE=SALDO_INICIAL;
  - all pulse outputs, ADVERTENCIA and BLOQUEO 0.
- All inputs are sampled at the rising edge. Outputs are registered.
- A pulse output is high for exactly the one cycle after the sampling edge that caused it.
- PIN latency: the last correct digit strobed at edge N puts the state in TRANS after edge N. If pending-valid is already set, the transaction pulses are high after edge N+1.
- BLOQUEO rises on the same edge as the final PIN_INCORRECTO pulse.
- Simultaneous events:
  - DIGITO_STB and MONTO_STB together: both are processed.
  - RESET overrides everything.
  - Card drop in the same cycle as DIGITO_STB: the abort wins and the digit is ignored.
- The timeout counter resets on every DIGITO_STB and on entry to PIN_ENTRY. It saturates and never wraps.

## Structure
- Package atm_pkg holds:
  - state enum atm_state_t;
  - a function for the error-counter width, clog2(MAX_INTENTOS+1);
  - a BCD digit typedef.
- Sub-module atm_pin_checker holds the digit index, comparator, error counter and timeout counter. It outputs match_done, mismatch, blocked and timeout to the top FSM.
- The top level holds the FSM, the amount latch and the balance datapath.

## Test plan
- PIN=0x6767, deposit MONTO=150000, digits 6,7,6,7 → BALANCE_ACTUALIZADO pulse, BALANCE=450000.
- After RESET, withdrawal of 350000 with the correct PIN → FONDOS_INSUFICIENTES pulse, BALANCE=300000, no ENTREGAR_DINERO.
- After RESET, withdrawal of 300000 → ENTREGAR_DINERO and BALANCE_ACTUALIZADO in the same cycle, BALANCE=0. Withdrawal of 600000 → LIMITE_EXCEDIDO only.
- Wrong-PIN lockout, digit sequence:
  - 6,7,1 → PIN_INCORRECTO, errors=1;
  - 6,7,6,1 → PIN_INCORRECTO, ADVERTENCIA=1;
  - 6,9 → PIN_INCORRECTO, BLOQUEO=1;
  - 6,7,6,7 and card removal → no response; RESET clears BLOQUEO.
- Card inserted, 6 strobed, then 64 idle cycles → TIMEOUT pulse, state IDLE, errors unchanged.
- Parameter variant: PIN_DIGITS=6, MONTO_W=16. A deposit of 65000 onto 1000 → BALANCE=65535 (saturated).

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, BCD digit and
// the error-counter width helper.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PIN_ENTRY = 3'd1,
    TRANS     = 3'd2,
    DONE      = 3'd3,
    BLOCKED   = 3'd4
  } atm_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Counter must be able to hold MAX_INTENTOS itself (the lockout value).
  function automatic int err_cnt_w(input int max_intentos);
    return $clog2(max_intentos + 1);
  endfunction

endpackage

// File: rtl/atm_pin_checker.sv
// Digit-by-digit PIN comparator with wrong-attempt counter and digit-entry
// idle timer. Emits single-cycle events to the session FSM.
module atm_pin_checker
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS   = 4,
  parameter int MAX_INTENTOS = 3,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                active,
  input  logic [4*PIN_DIGITS-1:0]             pin,
  input  bcd_digit_t                          digit,
  input  logic                                digit_stb,
  output logic                                match_done,
  output logic                                mismatch,
  output logic                                blocked,
  output logic                                timeout,
  output logic [err_cnt_w(MAX_INTENTOS)-1:0]  errors
);

  localparam int IW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int EW = err_cnt_w(MAX_INTENTOS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PIN_DIGITS - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] IDLE_SAT  = TW'(TIMEOUT_CYC);
  localparam logic [EW-1:0] ERR_LAST  = EW'(MAX_INTENTOS - 1);

  logic [IW-1:0] idx;
  logic [TW-1:0] idle_cnt;
  bcd_digit_t    expected;
  logic          hit;

  // Select the PIN digit awaited at the current index (MS digit first).
  always_comb begin
    expected = '0;
    for (int i = 0; i < PIN_DIGITS; i++)
      if (idx == IW'(i)) expected = pin[4*(PIN_DIGITS-1-i) +: 4];
  end

  // active already folds in card presence, so a card drop masks the digit.
  assign hit        = active && digit_stb && (digit == expected);
  assign match_done = hit && (idx == LAST_IDX);
  assign mismatch   = active && digit_stb && (digit != expected);
  assign blocked    = mismatch && (errors == ERR_LAST);
  assign timeout    = active && !digit_stb && (idle_cnt == IDLE_LAST);

  // Index, idle timer and persistent error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      idle_cnt <= '0;
      errors   <= '0;
    end else begin
      // Outside entry both index and timer sit at zero, so every entry
      // into PIN_ENTRY starts from a clean attempt.
      if (!active || match_done || mismatch || timeout) idx <= '0;
      else if (hit)                                    idx <= idx + IW'(1);

      if (!active || digit_stb)     idle_cnt <= '0;
      else if (idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + TW'(1);

      if (match_done)    errors <= '0;
      else if (mismatch) errors <= errors + EW'(1);
    end
  end

endmodule

// File: rtl/atm_ctrl_param.sv
// ATM session controller: card/PIN FSM, pending-amount latch and the
// saturating balance datapath with withdrawal limit and funds checks.
module atm_ctrl_param
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS    = 4,
  parameter int MONTO_W       = 32,
  parameter int MAX_INTENTOS  = 3,
  parameter int SALDO_INICIAL = 300000,
  parameter int LIMITE_RETIRO = 500000,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic [4*PIN_DIGITS-1:0] PIN,
  input  logic [3:0]              DIGITO,
  input  logic                    DIGITO_STB,
  input  logic                    TIPO_TRANS,
  input  logic [MONTO_W-1:0]      MONTO,
  input  logic                    MONTO_STB,
  output logic [MONTO_W-1:0]      BALANCE,
  output logic                    BALANCE_ACTUALIZADO,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    LIMITE_EXCEDIDO,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    BLOQUEO,
  output logic                    TIMEOUT
);

  localparam int EW = err_cnt_w(MAX_INTENTOS);
  localparam logic [MONTO_W-1:0] SALDO0 = MONTO_W'(SALDO_INICIAL);

  atm_state_t         state, state_nxt;
  logic [MONTO_W-1:0] pend_amt;
  logic               pend_wd;
  logic               pend_vld;
  logic               active;
  logic               match_done, mismatch, blocked, timeout;
  logic [EW-1:0]      errors;
  logic               execute;
  logic [MONTO_W:0]   dep_sum;
  logic               over_limit, no_funds;

  assign active = (state == PIN_ENTRY) && TARJETA_RECIBIDA;

  atm_pin_checker #(
    .PIN_DIGITS   (PIN_DIGITS),
    .MAX_INTENTOS (MAX_INTENTOS),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) u_pin (
    .clk        (CLK),
    .reset      (RESET),
    .active     (active),
    .pin        (PIN),
    .digit      (DIGITO),
    .digit_stb  (DIGITO_STB),
    .match_done (match_done),
    .mismatch   (mismatch),
    .blocked    (blocked),
    .timeout    (timeout),
    .errors     (errors)
  );

  assign execute    = (state == TRANS) && TARJETA_RECIBIDA && pend_vld;
  assign dep_sum    = {1'b0, BALANCE} + {1'b0, pend_amt};
  assign over_limit = 64'(pend_amt) > 64'(LIMITE_RETIRO);
  assign no_funds   = pend_amt > BALANCE;

  assign ADVERTENCIA = (errors == EW'(MAX_INTENTOS - 1));
  assign BLOQUEO     = (state == BLOCKED);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: card removal aborts before any digit or transaction event.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (TARJETA_RECIBIDA) state_nxt = PIN_ENTRY;
      PIN_ENTRY: begin
        if (!TARJETA_RECIBIDA) state_nxt = IDLE;
        else if (blocked)      state_nxt = BLOCKED;
        else if (match_done)   state_nxt = TRANS;
        else if (timeout)      state_nxt = IDLE;
      end
      TRANS: begin
        if (!TARJETA_RECIBIDA) state_nxt = IDLE;
        else if (pend_vld)     state_nxt = DONE;
      end
      DONE:      if (!TARJETA_RECIBIDA) state_nxt = IDLE;
      BLOCKED:   state_nxt = BLOCKED;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pending amount latch; a strobe coinciding with the executing cycle is
  // kept for the next card rather than lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_vld <= 1'b0;
      pend_amt <= '0;
      pend_wd  <= 1'b0;
    end else begin
      if (execute) pend_vld <= 1'b0;
      if (state != BLOCKED && MONTO_STB) begin
        pend_amt <= MONTO;
        pend_wd  <= TIPO_TRANS;
        pend_vld <= 1'b1;
      end
    end
  end

  // Balance update and registered event pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BALANCE              <= SALDO0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      TIMEOUT              <= 1'b0;
    end else begin
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO      <= 1'b0;
      PIN_INCORRECTO       <= mismatch;
      TIMEOUT              <= timeout;
      if (execute) begin
        if (!pend_wd) begin
          BALANCE             <= dep_sum[MONTO_W] ? '1 : dep_sum[MONTO_W-1:0];
          BALANCE_ACTUALIZADO <= 1'b1;
        end else if (over_limit) begin
          LIMITE_EXCEDIDO <= 1'b1;
        end else if (no_funds) begin
          FONDOS_INSUFICIENTES <= 1'b1;
        end else begin
          BALANCE             <= BALANCE - pend_amt;
          BALANCE_ACTUALIZADO <= 1'b1;
          ENTREGAR_DINERO     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Bench for atm_ctrl_param: scenario tasks plus a randomized run, all traced
// against a session-level reference model; second instance covers the
// 6-digit / 16-bit variant.
module tb_atm_ctrl_param;

  localparam int     NDIG  = 4;
  localparam int     MAXI  = 3;
  localparam int     TOC   = 64;
  localparam longint SALDO = 300000;
  localparam longint LIM   = 500000;
  localparam longint MAXB  = 64'hFFFF_FFFF;

  typedef struct {
    bit       rst, card, dstb;
    bit [3:0] dig;
    bit       mstb, typ;
    longint   amt;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, card, dstb, mstb, typ;
  logic [15:0] pin;
  logic [3:0]  dig;
  logic [31:0] amt;
  logic [31:0] bal_o;
  logic        upd, ent, fon, lim, pinc, adv, blq, tmo;

  logic        v_rst, v_card, v_dstb, v_mstb, v_typ;
  logic [23:0] v_pin;
  logic [3:0]  v_dig;
  logic [15:0] v_amt, v_bal;
  logic        v_upd, v_ent, v_fon, v_lim, v_pinc, v_adv, v_blq, v_tmo;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  atm_ctrl_param dut (
    .CLK(clk), .RESET(rst), .TARJETA_RECIBIDA(card), .PIN(pin), .DIGITO(dig),
    .DIGITO_STB(dstb), .TIPO_TRANS(typ), .MONTO(amt), .MONTO_STB(mstb),
    .BALANCE(bal_o), .BALANCE_ACTUALIZADO(upd), .ENTREGAR_DINERO(ent),
    .FONDOS_INSUFICIENTES(fon), .LIMITE_EXCEDIDO(lim), .PIN_INCORRECTO(pinc),
    .ADVERTENCIA(adv), .BLOQUEO(blq), .TIMEOUT(tmo)
  );

  atm_ctrl_param #(.PIN_DIGITS(6), .MONTO_W(16), .SALDO_INICIAL(1000)) dut_v (
    .CLK(clk), .RESET(v_rst), .TARJETA_RECIBIDA(v_card), .PIN(v_pin), .DIGITO(v_dig),
    .DIGITO_STB(v_dstb), .TIPO_TRANS(v_typ), .MONTO(v_amt), .MONTO_STB(v_mstb),
    .BALANCE(v_bal), .BALANCE_ACTUALIZADO(v_upd), .ENTREGAR_DINERO(v_ent),
    .FONDOS_INSUFICIENTES(v_fon), .LIMITE_EXCEDIDO(v_lim), .PIN_INCORRECTO(v_pinc),
    .ADVERTENCIA(v_adv), .BLOQUEO(v_blq), .TIMEOUT(v_tmo)
  );

  // ---------------- reference model (session level) ----------------
  // ph: 0 no session, 1 entering PIN, 2 authorised, 3 served, 4 locked out
  int     ph, errs, idle;
  int     entered[$];
  int     pin_d[$];
  longint bal, p_amt;
  bit     p_wd, p_have;
  logic [39:0] exp_v, act_v;

  function automatic stim_t st(input bit r, c, ds, input int d, input bit ms, t, input longint a);
    stim_t s;
    s.rst = r; s.card = c; s.dstb = ds; s.dig = 4'(d); s.mstb = ms; s.typ = t; s.amt = a;
    return s;
  endfunction
  function automatic stim_t sd(input int d);  return st(0, 1, 1, d, 0, 0, 0); endfunction
  function automatic stim_t si(input bit c);  return st(0, c, 0, 0, 0, 0, 0); endfunction

  task automatic set_pin(input logic [15:0] v);
    pin = v;
    pin_d.delete();
    for (int i = 0; i < NDIG; i++) pin_d.push_back(int'(v[4*(NDIG-1-i) +: 4]));
  endtask

  task automatic model_step(input stim_t s);
    longint o_amt;
    bit o_wd, o_have;
    bit e_upd, e_ent, e_fon, e_lim, e_pin, e_to;
    {e_upd, e_ent, e_fon, e_lim, e_pin, e_to} = '0;
    if (s.rst) begin
      ph = 0; errs = 0; idle = 0; entered.delete(); p_have = 0; bal = SALDO;
    end else if (ph != 4) begin
      o_amt = p_amt; o_wd = p_wd; o_have = p_have;
      if (s.mstb) begin p_amt = s.amt; p_wd = s.typ; p_have = 1; end
      case (ph)
        0: if (s.card) begin ph = 1; entered.delete(); idle = 0; end
        1: if (!s.card) ph = 0;
           else if (s.dstb) begin
             idle = 0;
             entered.push_back(int'(s.dig));
             if (entered[entered.size()-1] != pin_d[entered.size()-1]) begin
               e_pin = 1; errs++; entered.delete();
               if (errs == MAXI) ph = 4;
             end else if (entered.size() == NDIG) begin
               errs = 0; entered.delete(); ph = 2;
             end
           end else begin
             idle++;
             if (idle == TOC) begin e_to = 1; ph = 0; end
           end
        2: if (!s.card) ph = 0;
           else if (o_have) begin
             if (!o_wd) begin
               bal = (bal + o_amt > MAXB) ? MAXB : bal + o_amt; e_upd = 1;
             end else if (o_amt > LIM) e_lim = 1;
             else if (o_amt > bal)     e_fon = 1;
             else begin bal = bal - o_amt; e_upd = 1; e_ent = 1; end
             ph = 3;
             p_have = s.mstb;
           end
        3: if (!s.card) ph = 0;
        default: ;
      endcase
    end
    exp_v = {bal[31:0], e_upd, e_ent, e_fon, e_lim, e_pin, (errs == MAXI-1), (ph == 4), e_to};
  endtask

  task automatic cycle(input stim_t s);
    rst = s.rst; card = s.card; dstb = s.dstb; dig = s.dig;
    mstb = s.mstb; typ = s.typ; amt = s.amt[31:0];
    model_step(s);
    @(posedge clk); #1;
    act_v = {bal_o, upd, ent, fon, lim, pinc, adv, blq, tmo};
  endtask

  task automatic vcyc(input bit r, c, ds, input int d, input bit ms, t, input int a);
    v_rst = r; v_card = c; v_dstb = ds; v_dig = 4'(d); v_mstb = ms; v_typ = t; v_amt = 16'(a);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_pin(16'h6767);
    cycle(st(1, 0, 0, 0, 0, 0, 0));
    n_checks++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL reset_trace got %h want %h", act_v, exp_v); end
    n_checks++;
    if (act_v !== {32'd300000, 8'h00}) begin n_err++; $display("FAIL reset_state got %h want %h", act_v, {32'd300000, 8'h00}); end
  endtask

  task automatic test_deposit();
    stim_t q[$];
    logic [39:0] snap = '0;
    q = '{st(1,0,0,0,0,0,0), st(0,0,0,0,1,0,150000), si(1), sd(6), sd(7), sd(6), sd(7), si(1), si(0)};
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL deposit_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      if (i == 7) snap = act_v;
    end
    n_checks++;
    if (snap !== {32'd450000, 8'h80}) begin n_err++; $display("FAIL deposit_result got %h want %h", snap, {32'd450000, 8'h80}); end
  endtask

  task automatic test_insufficient();
    stim_t q[$];
    logic [39:0] snap = '0;
    q = '{st(1,0,0,0,0,0,0), st(0,1,0,0,1,1,350000), sd(6), sd(7), sd(6), sd(7), si(1), si(0)};
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL funds_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      if (i == 6) snap = act_v;
    end
    n_checks++;
    if (snap !== {32'd300000, 8'h20}) begin n_err++; $display("FAIL funds_result got %h want %h", snap, {32'd300000, 8'h20}); end
  endtask

  task automatic test_withdraw_limit();
    stim_t q[$];
    logic [39:0] s1 = '0, s2 = '0;
    q = '{st(1,0,0,0,0,0,0), st(0,0,0,0,1,1,300000), si(1), sd(6), sd(7), sd(6), sd(7), si(1), si(0),
          st(0,1,0,0,1,1,600000), sd(6), sd(7), sd(6), sd(7), si(1), si(0)};
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL withdraw_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      if (i == 7)  s1 = act_v;
      if (i == 14) s2 = act_v;
    end
    n_checks++;
    if (s1 !== {32'd0, 8'hC0}) begin n_err++; $display("FAIL withdraw_ok got %h want %h", s1, {32'd0, 8'hC0}); end
    n_checks++;
    if (s2 !== {32'd0, 8'h10}) begin n_err++; $display("FAIL withdraw_limit got %h want %h", s2, {32'd0, 8'h10}); end
  endtask

  task automatic test_lockout();
    stim_t q[$];
    logic [39:0] s[5];
    q = '{st(1,0,0,0,0,0,0), si(1), sd(6), sd(7), sd(1), sd(6), sd(7), sd(6), sd(1), sd(6), sd(9),
          sd(6), sd(7), sd(6), sd(7), si(0), st(0,0,0,0,1,0,1000), st(1,0,0,0,0,0,0)};
    foreach (s[k]) s[k] = '0;
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL lockout_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      case (i)
        4: s[0] = act_v;  8: s[1] = act_v;  10: s[2] = act_v;
        16: s[3] = act_v; 17: s[4] = act_v; default: ;
      endcase
    end
    n_checks++;
    if (s[0] !== {32'd300000, 8'h08}) begin n_err++; $display("FAIL lockout_err1 got %h want %h", s[0], {32'd300000, 8'h08}); end
    n_checks++;
    if (s[1] !== {32'd300000, 8'h0C}) begin n_err++; $display("FAIL lockout_warn got %h want %h", s[1], {32'd300000, 8'h0C}); end
    n_checks++;
    if (s[2] !== {32'd300000, 8'h0A}) begin n_err++; $display("FAIL lockout_block got %h want %h", s[2], {32'd300000, 8'h0A}); end
    n_checks++;
    if (s[3] !== {32'd300000, 8'h02}) begin n_err++; $display("FAIL lockout_sticky got %h want %h", s[3], {32'd300000, 8'h02}); end
    n_checks++;
    if (s[4] !== {32'd300000, 8'h00}) begin n_err++; $display("FAIL lockout_reset got %h want %h", s[4], {32'd300000, 8'h00}); end
  endtask

  task automatic test_timeout();
    stim_t q[$];
    logic [39:0] s_pre = '0, s_to = '0, s_ok = '0;
    int t_idx;
    q = '{st(1,0,0,0,0,0,0), si(1), sd(1), sd(2), si(0), si(1), sd(6)};
    repeat (TOC) q.push_back(si(1));
    t_idx = q.size() - 1;
    q.push_back(sd(6));   // lands in IDLE: ignored, card re-enters
    q.push_back(sd(6)); q.push_back(sd(7)); q.push_back(sd(6)); q.push_back(sd(7));
    q.push_back(si(0));
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL timeout_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      if (i == t_idx - 1) s_pre = act_v;
      if (i == t_idx)     s_to  = act_v;
      if (i == t_idx + 5) s_ok  = act_v;
    end
    n_checks++;
    if (s_pre !== {32'd300000, 8'h04}) begin n_err++; $display("FAIL timeout_early got %h want %h", s_pre, {32'd300000, 8'h04}); end
    n_checks++;
    if (s_to !== {32'd300000, 8'h05}) begin n_err++; $display("FAIL timeout_pulse got %h want %h", s_to, {32'd300000, 8'h05}); end
    n_checks++;
    if (s_ok !== {32'd300000, 8'h00}) begin n_err++; $display("FAIL timeout_reentry got %h want %h", s_ok, {32'd300000, 8'h00}); end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    logic [39:0] s_ab = '0, s_1 = '0, s_2 = '0;
    q = '{st(1,0,0,0,0,0,0), si(1), sd(6), sd(7), sd(6), st(0,0,1,7,0,0,0),
          st(0,1,0,0,1,0,10), sd(6), sd(7), sd(6), st(0,1,1,7,1,0,20), si(1),
          st(0,1,1,6,1,0,5), si(0), si(1), sd(6), sd(7), sd(6), sd(7), si(1), si(0)};
    foreach (q[i]) begin
      cycle(q[i]);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL b2b_trace cyc %0d got %h want %h", i, act_v, exp_v); end
      if (i == 5)  s_ab = act_v;
      if (i == 11) s_1  = act_v;
      if (i == 19) s_2  = act_v;
    end
    n_checks++;
    if (s_ab !== {32'd300000, 8'h00}) begin n_err++; $display("FAIL b2b_abort got %h want %h", s_ab, {32'd300000, 8'h00}); end
    n_checks++;
    if (s_1 !== {32'd300020, 8'h80}) begin n_err++; $display("FAIL b2b_overwrite got %h want %h", s_1, {32'd300020, 8'h80}); end
    n_checks++;
    if (s_2 !== {32'd300025, 8'h80}) begin n_err++; $display("FAIL b2b_pending got %h want %h", s_2, {32'd300025, 8'h80}); end
  endtask

  task automatic test_random();
    stim_t s;
    logic [15:0] npin;
    for (int n = 0; n < 4000; n++) begin
      s = si(1);
      s.rst  = ($urandom_range(0, 149) == 0) || (ph == 4 && $urandom_range(0, 9) == 0) || n == 0;
      s.card = ($urandom_range(0, 24) != 0);
      s.dstb = ($urandom_range(0, 2) == 0);
      if (ph == 1 && entered.size() < NDIG && $urandom_range(0, 11) != 0)
        s.dig = 4'(pin_d[entered.size()]);
      else
        s.dig = 4'($urandom_range(0, 9));
      s.mstb = ($urandom_range(0, 5) == 0);
      s.typ  = 1'($urandom_range(0, 1));
      s.amt  = ($urandom_range(0, 3) == 0) ? longint'($urandom()) : longint'($urandom_range(0, 700000));
      if (s.rst) begin
        for (int k = 0; k < NDIG; k++) npin[4*k +: 4] = 4'($urandom_range(0, 9));
        set_pin(npin);
      end
      cycle(s);
      n_checks++;
      if (act_v !== exp_v) begin n_err++; $display("FAIL random_trace cyc %0d got %h want %h", n, act_v, exp_v); end
    end
  endtask

  task automatic test_variant();
    vcyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (v_bal !== 16'd1000) begin n_err++; $display("FAIL variant_reset got %0d want %0d", v_bal, 1000); end
    vcyc(0, 0, 0, 0, 1, 0, 65000);
    vcyc(0, 1, 0, 0, 0, 0, 0);
    for (int d = 1; d <= 5; d++) vcyc(0, 1, 1, d, 0, 0, 0);
    vcyc(0, 1, 1, 9, 0, 0, 0);
    n_checks++;
    if ({v_pinc, v_upd} !== 2'b10) begin n_err++; $display("FAIL variant_wrong6 got %b want %b", {v_pinc, v_upd}, 2'b10); end
    for (int d = 1; d <= 6; d++) vcyc(0, 1, 1, d, 0, 0, 0);
    vcyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({v_bal, v_upd, v_ent} !== {16'hFFFF, 2'b10}) begin
      n_err++; $display("FAIL variant_saturate got %h want %h", {v_bal, v_upd, v_ent}, {16'hFFFF, 2'b10});
    end
    vcyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; card = 0; dstb = 0; mstb = 0; typ = 0; dig = 0; amt = 0; pin = 16'h6767;
    v_rst = 1; v_card = 0; v_dstb = 0; v_mstb = 0; v_typ = 0; v_dig = 0; v_amt = 0; v_pin = 24'h123456;
    ph = 0; errs = 0; idle = 0; bal = SALDO; p_amt = 0; p_wd = 0; p_have = 0;
    test_reset();
    test_deposit();
    test_insufficient();
    test_withdraw_limit();
    test_lockout();
    test_timeout();
    test_back_to_back();
    set_pin(16'h6767);
    test_random();
    test_variant();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
